// File: rtl/ters_zigzag.sv
// Run-length token expander: turns (run, value) / EOB tokens into 64 coefficients
// per block in zigzag order, each tagged with its natural (row, col) position.
module ters_zigzag #(
    parameter int PIXEL_BIT = 16,
    parameter int BLOCK_BIT = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [5:0]           rle_run_i,
    input  logic [PIXEL_BIT-1:0] rle_deger_i,
    input  logic                 rle_eob_i,
    input  logic                 rle_gecerli_i,
    output logic                 rle_hazir_o,
    output logic [PIXEL_BIT-1:0] zig_veri_o,
    output logic [BLOCK_BIT-1:0] zig_veri_row_o,
    output logic [BLOCK_BIT-1:0] zig_veri_col_o,
    output logic                 zig_veri_gecerli_o,
    input  logic                 zig_veri_hazir_i,
    output logic                 blok_son_o,
    output logic                 hata_o
);

    typedef enum logic [1:0] {KABUL, SIFIR, DEGER, DOLDUR} state_t;

    // Zigzag index -> natural raster position (row*8 + col).
    localparam logic [5:0] ZZ_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    state_t               state_q, state_d;
    logic [5:0]           pos_q, pos_d;
    logic [5:0]           rem_q, rem_d;
    logic [PIXEL_BIT-1:0] val_q, val_d;
    logic [PIXEL_BIT-1:0] veri_q, veri_d;
    logic [BLOCK_BIT-1:0] row_q, row_d;
    logic [BLOCK_BIT-1:0] col_q, col_d;
    logic                 gecerli_q, gecerli_d;
    logic                 son_q, son_d;
    logic                 hata_q, hata_d;

    logic                 adv;
    logic                 load;
    logic [PIXEL_BIT-1:0] load_val;
    logic [5:0]           nat;
    logic [6:0]           run_end;
    logic                 pos_last;

    assign adv         = !gecerli_q || zig_veri_hazir_i;
    assign rle_hazir_o = (state_q == KABUL) && adv;
    assign nat         = ZZ_NAT[pos_q];
    assign run_end     = {1'b0, pos_q} + {1'b0, rle_run_i};
    assign pos_last    = (pos_q == 6'd63);

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        rem_d     = rem_q;
        val_d     = val_q;
        veri_d    = veri_q;
        row_d     = row_q;
        col_d     = col_q;
        gecerli_d = gecerli_q;
        son_d     = son_q;
        hata_d    = 1'b0;
        load      = 1'b0;
        load_val  = '0;
        if (adv) begin
            unique case (state_q)
                KABUL: begin
                    if (rle_gecerli_i) begin
                        load = 1'b1;
                        if (rle_eob_i) begin
                            state_d = pos_last ? KABUL : DOLDUR;
                        end else if (rle_run_i == 6'd0) begin
                            load_val = rle_deger_i;
                        end else if (run_end > 7'd63) begin
                            // Run would spill past the block: pad to its end and drop the value.
                            hata_d  = 1'b1;
                            state_d = pos_last ? KABUL : DOLDUR;
                        end else begin
                            val_d   = rle_deger_i;
                            rem_d   = rle_run_i - 6'd1;
                            state_d = (rle_run_i != 6'd1) ? SIFIR : DEGER;
                        end
                    end
                end
                SIFIR: begin
                    load  = 1'b1;
                    rem_d = rem_q - 6'd1;
                    if (rem_q == 6'd1) state_d = DEGER;
                end
                DEGER: begin
                    load     = 1'b1;
                    load_val = val_q;
                    state_d  = KABUL;
                end
                DOLDUR: begin
                    load = 1'b1;
                    if (pos_last) state_d = KABUL;
                end
                default: state_d = KABUL;
            endcase
            if (load) begin
                veri_d    = load_val;
                row_d     = BLOCK_BIT'(nat[5:3]);
                col_d     = BLOCK_BIT'(nat[2:0]);
                son_d     = pos_last;
                gecerli_d = 1'b1;
                pos_d     = pos_q + 6'd1;
            end else begin
                gecerli_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= KABUL;
            pos_q     <= '0;
            rem_q     <= '0;
            val_q     <= '0;
            veri_q    <= '0;
            row_q     <= '0;
            col_q     <= '0;
            gecerli_q <= 1'b0;
            son_q     <= 1'b0;
            hata_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            rem_q     <= rem_d;
            val_q     <= val_d;
            veri_q    <= veri_d;
            row_q     <= row_d;
            col_q     <= col_d;
            gecerli_q <= gecerli_d;
            son_q     <= son_d;
            hata_q    <= hata_d;
        end
    end

    assign zig_veri_o         = veri_q;
    assign zig_veri_row_o     = row_q;
    assign zig_veri_col_o     = col_q;
    assign zig_veri_gecerli_o = gecerli_q;
    assign blok_son_o         = son_q;
    assign hata_o             = hata_q;

endmodule

// File: tb/tb_ters_zigzag.sv
// Self-checking bench for ters_zigzag: token streams are expanded by a simple
// position-walking model and compared against the captured output stream.
module tb_ters_zigzag;

    localparam int PB = 16;
    localparam int BB = 3;

    typedef struct packed {
        logic          eob;
        logic [5:0]    run;
        logic [PB-1:0] val;
    } tok_t;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [5:0]    rle_run_i;
    logic [PB-1:0] rle_deger_i;
    logic          rle_eob_i;
    logic          rle_gecerli_i;
    logic          rle_hazir_o;
    logic [PB-1:0] zig_veri_o;
    logic [BB-1:0] zig_veri_row_o;
    logic [BB-1:0] zig_veri_col_o;
    logic          zig_veri_gecerli_o;
    logic          zig_veri_hazir_i;
    logic          blok_son_o;
    logic          hata_o;

    ters_zigzag #(.PIXEL_BIT(PB), .BLOCK_BIT(BB)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .rle_run_i          (rle_run_i),
        .rle_deger_i        (rle_deger_i),
        .rle_eob_i          (rle_eob_i),
        .rle_gecerli_i      (rle_gecerli_i),
        .rle_hazir_o        (rle_hazir_o),
        .zig_veri_o         (zig_veri_o),
        .zig_veri_row_o     (zig_veri_row_o),
        .zig_veri_col_o     (zig_veri_col_o),
        .zig_veri_gecerli_o (zig_veri_gecerli_o),
        .zig_veri_hazir_i   (zig_veri_hazir_i),
        .blok_son_o         (blok_son_o),
        .hata_o             (hata_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    tok_t         tok_q[$];
    logic [22:0]  exp_q[$];
    logic [22:0]  obs_q[$];
    int           exp_hata;
    int           hata_cnt;
    int           hz_low_cnt;

    wire [22:0] cur = {zig_veri_o, zig_veri_row_o, zig_veri_col_o, blok_son_o};

    // Walk the anti-diagonals of the 8x8 block to find (row, col) of a zigzag index.
    function automatic logic [5:0] zz_rc(input int idx);
        int k = 0;
        logic [5:0] res = '0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            for (int j = 0; j <= hi - lo; j++) begin
                int r = (s % 2 == 0) ? hi - j : lo + j;
                if (k == idx) res = {r[2:0], 3'(s - r)};
                k++;
            end
        end
        return res;
    endfunction

    function automatic void push_exp(input logic [PB-1:0] v, input int p);
        exp_q.push_back({v, zz_rc(p), (p == 63)});
    endfunction

    function automatic void build_model();
        int pos = 0;
        exp_q.delete();
        exp_hata = 0;
        foreach (tok_q[t]) begin
            if (tok_q[t].eob || pos + int'(tok_q[t].run) > 63) begin
                if (!tok_q[t].eob) exp_hata++;
                for (int p = pos; p < 64; p++) push_exp('0, p);
                pos = 0;
            end else begin
                for (int k = 0; k < int'(tok_q[t].run); k++) begin
                    push_exp('0, pos);
                    pos++;
                end
                push_exp(tok_q[t].val, pos);
                pos = (pos == 63) ? 0 : pos + 1;
            end
        end
    endfunction

    task automatic idle_inputs();
        rle_gecerli_i = 1'b0;
        rle_eob_i     = 1'b0;
        rle_run_i     = '0;
        rle_deger_i   = '0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        idle_inputs();
        zig_veri_hazir_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic add_tok(input logic eob, input int run, input int val);
        tok_t t;
        t.eob = eob;
        t.run = 6'(run);
        t.val = PB'(val);
        tok_q.push_back(t);
    endtask

    // Drives tok_q with optional random backpressure and captures every transfer.
    task automatic run_tokens(input bit rand_hz);
        int idx = 0;
        int cyc = 0;
        int tail = 0;
        bit stall = 0;
        logic [22:0] prev = '0;
        obs_q.delete();
        hata_cnt   = 0;
        hz_low_cnt = 0;
        while (tail < 8 && cyc < 20000) begin
            @(negedge clk_i);
            cyc++;
            if (hata_o) hata_cnt++;
            if (stall) begin
                checks++;
                if (cur !== prev) begin
                    errors++;
                    $display("FAIL hold got %h exp %h", cur, prev);
                end
            end
            zig_veri_hazir_i = rand_hz ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < tok_q.size()) begin
                rle_gecerli_i = 1'b1;
                rle_eob_i     = tok_q[idx].eob;
                rle_run_i     = tok_q[idx].run;
                rle_deger_i   = tok_q[idx].val;
            end else begin
                idle_inputs();
            end
            #1;
            if (zig_veri_gecerli_o && zig_veri_hazir_i) obs_q.push_back(cur);
            stall = zig_veri_gecerli_o && !zig_veri_hazir_i;
            prev  = cur;
            if (!rle_hazir_o && zig_veri_hazir_i) hz_low_cnt++;
            if (rle_gecerli_i && rle_hazir_o) begin
                $display("token %0d eob=%0d run=%0d val=%0d", idx, rle_eob_i, rle_run_i,
                         $signed(rle_deger_i));
                idx++;
            end
            if (idx == tok_q.size() && obs_q.size() >= exp_q.size()) tail++;
        end
        idle_inputs();
        zig_veri_hazir_i = 1'b1;
        checks++;
        if (tail < 8) begin
            errors++;
            $display("FAIL timeout got %0d outputs exp %0d", obs_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({zig_veri_gecerli_o, zig_veri_o, zig_veri_row_o, zig_veri_col_o, blok_son_o, hata_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", cur);
        end
        checks++;
        if (rle_hazir_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_hazir got %b exp 1", rle_hazir_o);
        end
    endtask

    task automatic test_basic();
        do_reset();
        tok_q.delete();
        add_tok(0, 0, 5);
        add_tok(0, 2, -3);
        add_tok(1, 0, 0);
        build_model();
        run_tokens(0);
        checks++;
        if (obs_q.size() != 64) begin
            errors++;
            $display("FAIL basic_count got %0d exp 64", obs_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_eob_only();
        do_reset();
        tok_q.delete();
        add_tok(1, 0, 0);
        build_model();
        run_tokens(0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL eob_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL eob[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (hz_low_cnt != 63) begin
            errors++;
            $display("FAIL eob_hazir_low got %0d exp 63", hz_low_cnt);
        end
    endtask

    task automatic test_zrl();
        do_reset();
        tok_q.delete();
        repeat (4) add_tok(0, 15, 0);
        add_tok(1, 0, 0);
        build_model();
        run_tokens(0);
        checks++;
        if (obs_q.size() != 128 || hata_cnt != 0) begin
            errors++;
            $display("FAIL zrl_count got %0d/%0d exp 128/0", obs_q.size(), hata_cnt);
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL zrl[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        tok_q.delete();
        repeat (60) add_tok(0, 0, $urandom_range(1, 1000));
        add_tok(0, 5, 7);
        add_tok(0, 0, 21);
        build_model();
        run_tokens(0);
        checks++;
        if (hata_cnt != exp_hata || exp_hata != 1) begin
            errors++;
            $display("FAIL ovf_hata got %0d exp %0d", hata_cnt, exp_hata);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL ovf_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ovf[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk_i);
        rle_gecerli_i = 1'b1;
        rle_run_i     = 6'd40;
        rle_deger_i   = 16'd5;
        #1;
        checks++;
        if (rle_hazir_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_accept got %b exp 1", rle_hazir_o);
        end
        @(negedge clk_i);
        idle_inputs();
        repeat (29) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({zig_veri_gecerli_o, cur, hata_o} !== '0) begin
            errors++;
            $display("FAIL mid_reset got %b/%h exp 0/0", zig_veri_gecerli_o, cur);
        end
        rst_i = 1'b0;
        tok_q.delete();
        add_tok(0, 0, 9);
        build_model();
        run_tokens(0);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL mid_next got %0d items first %h exp %h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : 23'h0, exp_q[0]);
        end
    endtask

    task automatic test_backpressure_random();
        do_reset();
        tok_q.delete();
        for (int t = 0; t < 60; t++) begin
            int r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 6);
            int v = $urandom_range(1, 65535);
            add_tok($urandom_range(0, 7) == 0, r, v);
        end
        add_tok(1, 0, 0);
        build_model();
        run_tokens(1);
        checks++;
        if (hata_cnt != exp_hata) begin
            errors++;
            $display("FAIL rnd_hata got %0d exp %0d", hata_cnt, exp_hata);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rnd_count got %0d exp %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rnd[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        zig_veri_hazir_i = 1'b1;
        idle_inputs();
        test_reset();
        test_basic();
        test_eob_only();
        test_zrl();
        test_overflow();
        test_reset_mid();
        test_backpressure_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
